glip_traffic_endpoint: RTL
==========================

GLIP_TRAFFIC_ENDPOINT -- requirements
Module: glip_traffic_endpoint

Interface
REQ-001 Parameters SHALL be WIDTH (default 16; channel data width, minimum 8) and BUF_DEPTH (default 4; loopback buffer entries, power of two, minimum 2).
REQ-002 clk_logic  input  1  logic clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fifo_in  glip_channel.slave  WIDTH  host-to-logic words; the block SHALL sample data/valid and drive ready.
REQ-005 fifo_out  glip_channel.master  WIDTH  logic-to-host words; the block SHALL drive data/valid and sample ready.
REQ-006 busy  output  1  high while any state other than IDLE is active.
REQ-007 done  output  1  one-cycle pulse when a command completes.
REQ-008 err_count  output  16  CHECK mismatch counter, saturating.
REQ-009 err_got, err_exp  output  WIDTH each  first mismatching word and its expected value (see Configuration).

Function
REQ-010 A transfer on either channel SHALL occur only in a cycle where valid and ready are both high at the rising edge.
REQ-011 In IDLE, fifo_in.ready SHALL be 1; an accepted word is a command: opcode = data[WIDTH-1:WIDTH-2], N = data[WIDTH-3:0].
REQ-012 Opcodes: 00 NOP, 01 GEN, 10 LOOP, 11 CHECK; the state SHALL change in the cycle after acceptance.
REQ-013 NOP, or any opcode with N=0, SHALL remain in IDLE and pulse done in the following cycle.
REQ-014 GEN: fifo_in.ready=0, fifo_out.valid=1, fifo_out.data = k mod 2^WIDTH, where k = 0,1,...,N-1 and k advances only on an out-handshake.
REQ-015 GEN: while fifo_out.ready is low, fifo_out.data and fifo_out.valid SHALL hold stable.
REQ-016 LOOP: the block SHALL accept exactly N further words into a FIFO of BUF_DEPTH entries and emit them unmodified, in order, on fifo_out.
REQ-017 LOOP: fifo_in.ready = (buffer not full) AND (remaining receive count > 0); readiness SHALL NOT depend on same-cycle pops.
REQ-018 LOOP: there SHALL be no bypass; a word is visible on fifo_out at the earliest one cycle after its acceptance; fifo_out.valid = buffer not empty.
REQ-019 LOOP: simultaneous push and pop SHALL be legal when the buffer is neither full nor empty; pointers SHALL wrap modulo BUF_DEPTH.
REQ-020 LOOP SHALL complete only when all N words have been received and the buffer is empty.
REQ-021 CHECK: fifo_in.ready=1 and fifo_out.valid=0; received word k SHALL be compared with k mod 2^WIDTH.
REQ-022 CHECK: err_count SHALL be cleared when the command is accepted and incremented per mismatch, saturating at 0xFFFF.
REQ-023 CHECK SHALL complete on the Nth accepted word.
REQ-024 Outside GEN and LOOP, fifo_out.valid SHALL be 0; outside IDLE, LOOP and CHECK, fifo_in.ready SHALL be 0.
REQ-025 On completion, the state SHALL return to IDLE and done SHALL be high for exactly one cycle, coincident with the first IDLE cycle.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL enter IDLE, flush the buffer, and zero all counters, err_count, err_got and err_exp.
REQ-027 After reset: fifo_out.valid=0, fifo_out.data=0, done=0, busy=0, fifo_in.ready=1 (IDLE); a reset mid-command SHALL abandon the command with no done pulse.

Configuration
REQ-028 Macro GLIP_TRAFFIC_ERR_CAPTURE_EN defined: on the first mismatch after a CHECK command is accepted, err_got and err_exp SHALL latch the received and expected words and hold them until the next CHECK acceptance or reset.
REQ-029 Macro GLIP_TRAFFIC_ERR_CAPTURE_EN undefined: err_got and err_exp SHALL be constant 0 and the capture registers SHALL NOT be generated; all other behaviour is unchanged.

Verification (WIDTH=16, BUF_DEPTH=4)
REQ-030 Send 0x4003 with fifo_out.ready=1 -> output 0x0000, 0x0001, 0x0002 on consecutive cycles; done pulses once; busy then returns to 0.
REQ-031 Send 0x4003 and hold fifo_out.ready=0 for 5 cycles -> fifo_out.data stays 0x0000 and fifo_out.valid stays 1 throughout; no word is lost after release.
REQ-032 Send 0x8005, then 0x00A1..0x00A5 with fifo_out.ready=0 -> fifo_in.ready drops after 4 words; after release, 0x00A1..0x00A5 are output in order, followed by done.
REQ-033 Send 0xC004, then 0x0000, 0x0001, 0x0007, 0x0003 -> err_count=1; with the macro: err_got=0x0007, err_exp=0x0002; without it: both 0.
REQ-034 Send 0x4008, assert rst after 2 words -> next cycle: valid=0, busy=0, no done pulse; a following 0x4002 outputs 0x0000, 0x0001.
REQ-035 Send 0x4000 or 0x0000 -> no fifo_out traffic; done pulses in the following cycle; busy stays 0.

Source files
------------

// File: rtl/glip_traffic_endpoint_if.sv
// glip_channel: one direction of a GLIP word channel.
//   data  : payload word, WIDTH bits, driven by the master
//   valid : master has a word on data
//   ready : slave can take a word this cycle
//
// Handshake: a word moves only at a rising clock edge where valid and ready
// are both high. A master that raises valid keeps data and valid stable
// until that edge. Ready may rise or fall freely and never depends on a
// transfer in the same cycle.
//
// Modports: master (drives data/valid, samples ready), slave (the reverse).
interface glip_channel #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glip_traffic_endpoint.sv
// glip_traffic_endpoint: command-driven traffic endpoint for a GLIP link.
// In IDLE it takes one command word from fifo_in:
//   opcode = data[WIDTH-1:WIDTH-2], N = data[WIDTH-3:0]
//   00 NOP   : nothing, done next cycle
//   01 GEN   : emit 0,1,...,N-1 on fifo_out
//   10 LOOP  : take N more words, buffer them, echo them on fifo_out
//   11 CHECK : take N more words, compare word k with k, count mismatches
// Any opcode with N=0 behaves like NOP.
//
// Ports:
//   clk_logic  logic clock, rising edge
//   rst        synchronous active-high reset
//   fifo_in    glip_channel.slave, host-to-logic words
//   fifo_out   glip_channel.master, logic-to-host words
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse on the first IDLE cycle after a command
//   err_count  saturating CHECK mismatch count
//   err_got    first mismatching word of the last CHECK
//   err_exp    expected value for err_got
//   state_dbg  current FSM state (IDLE=0, GEN=1, LOOP=2, CHECK=3)
//
// Optional feature: define GLIP_TRAFFIC_ERR_CAPTURE_EN to build the
// err_got/err_exp capture registers; without it both outputs are tied to 0.
module glip_traffic_endpoint #(
  parameter int WIDTH     = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk_logic,
  input  logic             rst,
  glip_channel.slave       fifo_in,
  glip_channel.master      fifo_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] err_got,
  output logic [WIDTH-1:0] err_exp,
  output logic [1:0]       state_dbg
);

  localparam int NW = WIDTH - 2;
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Encodings match the opcodes so a command maps straight onto a state.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GEN   = 2'b01,
    LOOP  = 2'b10,
    CHECK = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [NW-1:0]    n_q;
  logic [WIDTH-1:0] k_q;
  logic [NW-1:0]    rem_q, rem_d;

  logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;

  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;

  logic [1:0]       cmd_op;
  logic [NW-1:0]    cmd_n;
  logic [WIDTH-1:0] k_last;
  logic             last_k;
  logic             full, empty, loop_rdy;
  logic             idle_fire, gen_fire, chk_fire, push, pop;
  logic             mismatch, chk_accept;

  assign cmd_op = fifo_in.data[WIDTH-1:WIDTH-2];
  assign cmd_n  = fifo_in.data[NW-1:0];

  // n_q is never zero while GEN or CHECK is active, so N-1 does not wrap.
  assign k_last = {2'b00, n_q} - WIDTH'(1);
  assign last_k = (k_q == k_last);

  assign full     = (cnt_q == (AW+1)'(BUF_DEPTH));
  assign empty    = (cnt_q == '0);
  // Readiness comes only from registered state, never from a same-cycle pop.
  assign loop_rdy = !full && (rem_q != '0);

  // Handshake events, derived from registers and inputs only, so the
  // FSM below stays free of combinational loops through the interface.
  assign idle_fire = (state_q == IDLE)  && fifo_in.valid;
  assign gen_fire  = (state_q == GEN)   && fifo_out.ready;
  assign chk_fire  = (state_q == CHECK) && fifo_in.valid;
  assign push      = (state_q == LOOP)  && fifo_in.valid && loop_rdy;
  assign pop       = (state_q == LOOP)  && !empty && fifo_out.ready;

  assign mismatch   = chk_fire && (fifo_in.data != k_q);
  assign chk_accept = idle_fire && (cmd_op == 2'b11);

  assign rem_d = rem_q - NW'(push);
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  // FSM next state and channel outputs.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (idle_fire) begin
          if (cmd_op == 2'b00 || cmd_n == '0) done_d = 1'b1;
          else state_d = state_t'(cmd_op);
        end
      end
      GEN: begin
        out_valid = 1'b1;
        out_data  = k_q;
        if (gen_fire && last_k) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      LOOP: begin
        in_ready  = loop_rdy;
        out_valid = !empty;
        out_data  = buf_mem[rd_ptr_q];
        // Finish when nothing is left to receive and the buffer drains.
        if (rem_d == '0 && cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      CHECK: begin
        in_ready = 1'b1;
        if (chk_fire && last_k) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Counters, buffer pointers and the mismatch counter.
  always_ff @(posedge clk_logic) begin
    if (rst) begin
      n_q       <= '0;
      k_q       <= '0;
      rem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_count <= '0;
    end else begin
      if (idle_fire) begin
        n_q   <= cmd_n;
        k_q   <= '0;
        rem_q <= cmd_n;
      end
      if (gen_fire || chk_fire) k_q <= k_q + WIDTH'(1);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        rem_q    <= rem_d;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      if (chk_accept) err_count <= '0;
      else if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  // Buffer storage needs no reset: the count and pointers define validity.
  always_ff @(posedge clk_logic) begin
    if (push) buf_mem[wr_ptr_q] <= fifo_in.data;
  end

`ifdef GLIP_TRAFFIC_ERR_CAPTURE_EN
  logic             err_seen_q;
  logic [WIDTH-1:0] err_got_q, err_exp_q;

  // Only the first mismatch after a CHECK is accepted is kept.
  always_ff @(posedge clk_logic) begin
    if (rst) begin
      err_seen_q <= 1'b0;
      err_got_q  <= '0;
      err_exp_q  <= '0;
    end else if (chk_accept) begin
      err_seen_q <= 1'b0;
      err_got_q  <= '0;
      err_exp_q  <= '0;
    end else if (mismatch && !err_seen_q) begin
      err_seen_q <= 1'b1;
      err_got_q  <= fifo_in.data;
      err_exp_q  <= k_q;
    end
  end

  assign err_got = err_got_q;
  assign err_exp = err_exp_q;
`else
  assign err_got = '0;
  assign err_exp = '0;
`endif

  assign fifo_in.ready  = in_ready;
  assign fifo_out.valid = out_valid;
  assign fifo_out.data  = out_data;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
